gray_step_monitor: RTL and testbench

- Downstream consumer of the 4-bit BCD-to-Gray converter output.
- Samples the Gray code under a valid strobe and decodes it back to binary.
- Classifies each new sample as a step up, a step down, a repeat or an illegal jump, and keeps a signed position counter and a saturating error counter.
- Used as the checker/tracker stage after the converter in encoder-style datapaths.

---
 rtl/gray_step_monitor.sv | 198 +++++++++++++++++++
 tb/tb_gray_step_monitor.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/gray_step_monitor.sv
// gray_step_monitor
// Tracker stage that sits after a 4-bit Gray converter. It samples Gray
// codes under a valid strobe and decodes each one to binary. Each new sample
// is classified against the previous one as a repeat, a +1 step, a -1 step
// or an illegal jump. A signed position counter and a saturating error
// counter are maintained alongside.
// All outputs are registered, so a sample's effects appear one clock after
// the edge that captures it.
`timescale 1ns/1ps

module gray_step_monitor #(
  parameter int POS_W = 8,
  parameter int ERR_W = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [3:0]              gray_in,
  input  logic                    gray_valid,
  input  logic                    clear_err,
  output logic [3:0]              bin_out,
  output logic                    bin_valid,
  output logic                    step_up,
  output logic                    step_dn,
  output logic                    step_err,
  output logic signed [POS_W-1:0] pos,
  output logic [ERR_W-1:0]        err_count,
  output logic [1:0]              state_o
);

  // State encoding is visible on state_o, so the values are fixed.
  localparam logic [1:0] ST_IDLE  = 2'b00;
  localparam logic [1:0] ST_TRACK = 2'b01;
  localparam logic [1:0] ST_ERROR = 2'b10;

  // Difference classes between the new and previous binary samples (mod 16).
  localparam logic [3:0] DELTA_SAME = 4'd0;
  localparam logic [3:0] DELTA_UP   = 4'd1;
  localparam logic [3:0] DELTA_DN   = 4'd15;

  localparam logic signed [POS_W-1:0] POS_ONE = {{(POS_W-1){1'b0}}, 1'b1};
  localparam logic [ERR_W-1:0]        ERR_ONE = {{(ERR_W-1){1'b0}}, 1'b1};

  // Reflected-binary decode: each binary bit is the XOR of the Gray bits
  // at and above it.
  function automatic logic [3:0] gray_to_bin(input logic [3:0] g);
    logic [3:0] b;
    b[3] = g[3];
    b[2] = b[3] ^ g[2];
    b[1] = b[2] ^ g[1];
    b[0] = b[1] ^ g[0];
    return b;
  endfunction

  // Saturating increment for the error counter: stays at all-ones once reached.
  function automatic logic [ERR_W-1:0] sat_inc(input logic [ERR_W-1:0] v);
    logic [ERR_W-1:0] r;
    if (&v) begin
      r = v;
    end else begin
      r = v + ERR_ONE;
    end
    return r;
  endfunction

  // Registered state.
  logic [1:0]              state_r;
  logic [3:0]              prev_bin_r;
  logic                    bin_valid_r;
  logic                    step_up_r;
  logic                    step_dn_r;
  logic                    step_err_r;
  logic signed [POS_W-1:0] pos_r;
  logic [ERR_W-1:0]        err_cnt_r;

  // Next-state values.
  logic [1:0]              state_s;
  logic [3:0]              prev_bin_s;
  logic                    bin_valid_s;
  logic                    step_up_s;
  logic                    step_dn_s;
  logic                    step_err_s;
  logic signed [POS_W-1:0] pos_s;
  logic [ERR_W-1:0]        err_cnt_s;

  // Decoded sample and its distance from the previous sample.
  logic [3:0]              sample_bin_s;
  logic [3:0]              delta_s;

  // Decode the incoming code and form the modulo-16 step distance.
  always_comb begin
    sample_bin_s = gray_to_bin(gray_in);
    delta_s      = sample_bin_s - prev_bin_r;
  end

  // Classify the accepted sample and compute all next register values.
  always_comb begin
    state_s     = state_r;
    prev_bin_s  = prev_bin_r;
    bin_valid_s = 1'b0;
    step_up_s   = 1'b0;
    step_dn_s   = 1'b0;
    step_err_s  = 1'b0;
    pos_s       = pos_r;
    err_cnt_s   = err_cnt_r;

    if (gray_valid) begin
      // Every accepted sample updates the decoded value and the reference.
      bin_valid_s = 1'b1;
      prev_bin_s  = sample_bin_s;

      if (clear_err) begin
        // clear_err with a sample behaves as a fresh capture from IDLE.
        state_s = ST_TRACK;
      end else begin
        case (state_r)
          ST_IDLE: begin
            state_s = ST_TRACK;
          end
          ST_TRACK: begin
            case (delta_s)
              DELTA_SAME: begin
                state_s = ST_TRACK;
              end
              DELTA_UP: begin
                step_up_s = 1'b1;
                pos_s     = pos_r + POS_ONE;
                state_s   = ST_TRACK;
              end
              DELTA_DN: begin
                step_dn_s = 1'b1;
                pos_s     = pos_r - POS_ONE;
                state_s   = ST_TRACK;
              end
              default: begin
                // Any non-adjacent jump, including single-bit Gray changes
                // that are not neighbours in binary (e.g. 1 -> 14).
                step_err_s = 1'b1;
                err_cnt_s  = sat_inc(err_cnt_r);
                state_s    = ST_ERROR;
              end
            endcase
          end
          ST_ERROR: begin
            // Samples are tracked but pos and err_count stay frozen.
            state_s = ST_ERROR;
          end
          default: begin
            // Unreachable encoding: recover by treating the sample as a capture.
            state_s = ST_TRACK;
          end
        endcase
      end
    end else begin
      if (clear_err) begin
        state_s = ST_IDLE;
      end else if (state_r == 2'b11) begin
        // Unreachable encoding: fall back to a known state.
        state_s = ST_IDLE;
      end else begin
        state_s = state_r;
      end
    end
  end

  // Register every output and the tracking state; rst clears all of it at once.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r     <= ST_IDLE;
      prev_bin_r  <= 4'd0;
      bin_valid_r <= 1'b0;
      step_up_r   <= 1'b0;
      step_dn_r   <= 1'b0;
      step_err_r  <= 1'b0;
      pos_r       <= '0;
      err_cnt_r   <= '0;
    end else begin
      state_r     <= state_s;
      prev_bin_r  <= prev_bin_s;
      bin_valid_r <= bin_valid_s;
      step_up_r   <= step_up_s;
      step_dn_r   <= step_dn_s;
      step_err_r  <= step_err_s;
      pos_r       <= pos_s;
      err_cnt_r   <= err_cnt_s;
    end
  end

  // The previous-sample register doubles as the decoded output.
  assign bin_out   = prev_bin_r;
  assign bin_valid = bin_valid_r;
  assign step_up   = step_up_r;
  assign step_dn   = step_dn_r;
  assign step_err  = step_err_r;
  assign pos       = pos_r;
  assign err_count = err_cnt_r;
  assign state_o   = state_r;

endmodule

// File: tb/tb_gray_step_monitor.sv
// Testbench for gray_step_monitor: directed scenarios followed by random
// stimulus, every cycle compared against a behavioural model.
`timescale 1ns/1ps

module tb_gray_step_monitor;

  logic              clk;
  logic              rst;
  logic [3:0]        gray_in;
  logic              gray_valid;
  logic              clear_err;
  logic [3:0]        bin_out;
  logic              bin_valid;
  logic              step_up;
  logic              step_dn;
  logic              step_err;
  logic signed [7:0] pos;
  logic [7:0]        err_count;
  logic [1:0]        state_o;

  int checks = 0;
  int errors = 0;

  // Behavioural model: state 0 idle, 1 tracking, 2 error.
  int m_state, m_prev, m_pos, m_err;
  int m_bv, m_up, m_dn, m_se;

  gray_step_monitor #(.POS_W(8), .ERR_W(8)) dut (
    .clk(clk), .rst(rst), .gray_in(gray_in), .gray_valid(gray_valid),
    .clear_err(clear_err), .bin_out(bin_out), .bin_valid(bin_valid),
    .step_up(step_up), .step_dn(step_dn), .step_err(step_err), .pos(pos),
    .err_count(err_count), .state_o(state_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Watchdog so the run always ends.
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit expired");
    $fatal(1, "watchdog");
  end

  function automatic int g2b(input int g);
    return (g ^ (g >> 1) ^ (g >> 2) ^ (g >> 3)) & 15;
  endfunction

  function automatic int b2g(input int b);
    return (b ^ (b >> 1)) & 15;
  endfunction

  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_state = 0; m_prev = 0; m_pos = 0; m_err = 0;
    m_bv = 0; m_up = 0; m_dn = 0; m_se = 0;
  endtask

  task automatic model_step(input int v, input int g, input int c);
    int nb;
    int d;
    m_bv = 0; m_up = 0; m_dn = 0; m_se = 0;
    if (v != 0) begin
      nb = g2b(g);
      m_bv = 1;
      if (c != 0 || m_state == 0) begin
        m_state = 1;
      end else if (m_state == 1) begin
        d = (nb - m_prev + 16) % 16;
        if (d == 1) begin
          m_up = 1;
          m_pos = m_pos + 1;
          if (m_pos > 127) m_pos = m_pos - 256;
        end else if (d == 15) begin
          m_dn = 1;
          m_pos = m_pos - 1;
          if (m_pos < -128) m_pos = m_pos + 256;
        end else if (d != 0) begin
          m_se = 1;
          if (m_err < 255) m_err = m_err + 1;
          m_state = 2;
        end
      end
      m_prev = nb;
    end else if (c != 0) begin
      m_state = 0;
    end
  endtask

  task automatic check_all(input string ctx);
    check({ctx, ".bin_out"},   int'(bin_out),   m_prev);
    check({ctx, ".bin_valid"}, int'(bin_valid), m_bv);
    check({ctx, ".step_up"},   int'(step_up),   m_up);
    check({ctx, ".step_dn"},   int'(step_dn),   m_dn);
    check({ctx, ".step_err"},  int'(step_err),  m_se);
    check({ctx, ".pos"},       int'(pos),       m_pos);
    check({ctx, ".err_count"}, int'(err_count), m_err);
    check({ctx, ".state"},     int'(state_o),   m_state);
  endtask

  // Called at a negedge: drive inputs, let one posedge sample them, check.
  task automatic step(input logic v, input logic [3:0] g, input logic c, input string ctx);
    gray_valid = v;
    gray_in    = g;
    clear_err  = c;
    model_step(int'(v), int'(g), int'(c));
    @(posedge clk);
    #1;
    check_all(ctx);
    @(negedge clk);
  endtask

  // Raise rst between edges and check everything clears before the next edge.
  task automatic async_reset(input string ctx);
    gray_valid = 1'b0;
    clear_err  = 1'b0;
    gray_in    = 4'd0;
    #2;
    rst = 1'b1;
    #1;
    model_reset();
    check_all(ctx);
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    int nb;
    int r;
    logic v;
    logic c;

    rst = 1'b1;
    gray_in = 4'd0;
    gray_valid = 1'b0;
    clear_err = 1'b0;
    model_reset();
    #1;
    check_all("reset");
    @(negedge clk);
    rst = 1'b0;

    // Count 0,1,2,3.
    step(1'b1, 4'b0000, 1'b0, "cnt0");
    step(1'b1, 4'b0001, 1'b0, "cnt1");
    step(1'b1, 4'b0011, 1'b0, "cnt2");
    step(1'b1, 4'b0010, 1'b0, "cnt3");
    check("count_pos", int'(pos), 3);
    check("count_bin", int'(bin_out), 3);
    check("count_err", int'(err_count), 0);

    // Climb to 15, then wrap up to 0 and back down to 15.
    for (int b = 4; b < 16; b++) step(1'b1, 4'(b2g(b)), 1'b0, "climb");
    check("climb_pos", int'(pos), 15);
    step(1'b1, 4'b0000, 1'b0, "wrap_up");
    check("wrap_up_pulse", int'(step_up), 1);
    step(1'b1, 4'b1000, 1'b0, "wrap_dn");
    check("wrap_dn_pulse", int'(step_dn), 1);
    check("wrap_pos", int'(pos), 15);

    // Illegal 1 -> 14 jump, then a sample while in ERROR.
    step(1'b1, 4'b0000, 1'b0, "to0");
    step(1'b1, 4'b0001, 1'b0, "to1");
    step(1'b1, 4'b1001, 1'b0, "jump");
    check("jump_err", int'(step_err), 1);
    check("jump_cnt", int'(err_count), 1);
    check("jump_state", int'(state_o), 2);
    check("jump_pos", int'(pos), 17);
    step(1'b1, 4'b1101, 1'b0, "in_err");
    check("in_err_bin", int'(bin_out), 9);

    // Clear with simultaneous capture, then a legal step.
    step(1'b1, 4'b0110, 1'b1, "clr_cap");
    check("clr_state", int'(state_o), 1);
    check("clr_bin", int'(bin_out), 4);
    step(1'b1, 4'b0111, 1'b0, "after_clr");
    check("after_clr_up", int'(step_up), 1);

    // Clear without a sample returns to IDLE.
    step(1'b0, 4'b0000, 1'b1, "clr_idle");
    check("clr_idle_state", int'(state_o), 0);

    // Saturate the error counter.
    for (int i = 0; i < 300; i++) begin
      step(1'b1, 4'b0000, 1'b1, "sat_ref");
      step(1'b1, 4'b1100, 1'b0, "sat_jump");
    end
    check("sat_cnt", int'(err_count), 255);
    step(1'b0, 4'b0000, 1'b0, "idle");

    // 130 up-steps from pos 0 wrap to -126.
    async_reset("rst_a");
    step(1'b1, 4'b0000, 1'b0, "pw_cap");
    for (int i = 0; i < 130; i++) step(1'b1, 4'(b2g((i + 1) % 16)), 1'b0, "pw_step");
    check("pos_wrap", int'(pos), -126);

    // Asynchronous reset while tracking at pos 5.
    async_reset("rst_b");
    step(1'b1, 4'b0000, 1'b0, "ar_cap");
    for (int i = 1; i <= 5; i++) step(1'b1, 4'(b2g(i)), 1'b0, "ar_step");
    check("ar_pos", int'(pos), 5);
    async_reset("rst_mid");
    check("rst_mid_pos", int'(pos), 0);
    check("rst_mid_state", int'(state_o), 0);
    step(1'b1, 4'(b2g(6)), 1'b0, "post_rst");
    check("post_rst_up", int'(step_up), 0);
    check("post_rst_state", int'(state_o), 1);

    // Random traffic biased towards legal steps.
    for (int n = 0; n < 3000; n++) begin
      v = ($urandom_range(0, 3) != 0);
      c = ($urandom_range(0, 19) == 0);
      r = int'($urandom_range(0, 9));
      if (r < 3)      nb = (m_prev + 1) % 16;
      else if (r < 6) nb = (m_prev + 15) % 16;
      else if (r < 8) nb = m_prev;
      else            nb = int'($urandom_range(0, 15));
      step(v, 4'(b2g(nb)), c, "rand");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
